lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: one byte per request, with setup / enable-pulse / hold / settle timing.
// Optional power-up init sequence is compiled in when LCD_INIT_EN is defined.
module lcd_ctrl #(
   parameter int SETUP_CYC     = 2,
   parameter int EN_CYC        = 25,
   parameter int HOLD_CYC      = 2,
   parameter int WAIT_CYC      = 2500,
   parameter int LONG_WAIT_CYC = 82000,
   parameter int PWRUP_CYC     = 750000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_i,
   input  logic       rs_i,
   input  logic [7:0] data_i,
   input  logic       on_i,
   output logic       ready_o,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_ON
);

   localparam int CNT_W = 20;
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] LWAIT_LD = CNT_W'(LONG_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_WAIT
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             en_q;
   logic             rs_q;
   logic [7:0]       data_q;
   logic             on_q;
   logic [CNT_W-1:0] settle_ld_d;

   // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
   always_comb begin
      settle_ld_d = WAIT_LD;
      if (!rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0)) begin
         settle_ld_d = LWAIT_LD;
      end
   end

`ifdef LCD_INIT_EN
   localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(PWRUP_CYC - 2);

   logic       armed_q;
   logic       init_busy_q;
   logic [1:0] init_idx_q;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
`ifdef LCD_INIT_EN
         state_q     <= S_INIT;
         armed_q     <= 1'b0;
         init_busy_q <= 1'b0;
         init_idx_q  <= 2'd0;
`else
         state_q     <= S_IDLE;
`endif
         cnt_q   <= '0;
         ready_q <= 1'b0;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         on_q    <= 1'b0;
      end else begin
         on_q <= on_i;
         case (state_q)
`ifdef LCD_INIT_EN
            // First INIT cycle arms the power-up count; the rest count it down.
            S_INIT: begin
               if (!armed_q) begin
                  armed_q <= 1'b1;
                  cnt_q   <= PWR_LD;
               end else if (cnt_q == '0) begin
                  init_busy_q <= 1'b1;
                  init_idx_q  <= 2'd0;
                  rs_q        <= 1'b0;
                  data_q      <= init_cmd(2'd0);
                  cnt_q       <= SETUP_LD;
                  state_q     <= S_SETUP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
`endif
            S_IDLE: begin
               if (ready_q && req_i) begin
                  rs_q    <= rs_i;
                  data_q  <= data_i;
                  ready_q <= 1'b0;
                  cnt_q   <= SETUP_LD;
                  state_q <= S_SETUP;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_SETUP: begin
               if (cnt_q == '0) begin
                  en_q    <= 1'b1;
                  cnt_q   <= EN_LD;
                  state_q <= S_PULSE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_PULSE: begin
               if (cnt_q == '0) begin
                  en_q    <= 1'b0;
                  cnt_q   <= HOLD_LD;
                  state_q <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_HOLD: begin
               if (cnt_q == '0) begin
                  cnt_q   <= settle_ld_d;
                  state_q <= S_WAIT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                  // Init commands chain straight into the next SETUP without visiting IDLE.
                  if (init_busy_q && (init_idx_q != 2'd3)) begin
                     init_idx_q <= init_idx_q + 2'd1;
                     rs_q       <= 1'b0;
                     data_q     <= init_cmd(init_idx_q + 2'd1);
                     cnt_q      <= SETUP_LD;
                     state_q    <= S_SETUP;
                  end else begin
                     init_busy_q <= 1'b0;
                     state_q     <= S_IDLE;
                  end
`else
                  state_q <= S_IDLE;
`endif
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o  = ready_q;
   assign LCD_EN   = en_q;
   assign LCD_RS   = rs_q;
   assign LCD_DATA = data_q;
   assign LCD_RW   = 1'b0;
   assign LCD_ON   = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: transaction-level reference model, per-cycle compare, directed and random writes.
module tb_lcd_ctrl;
  localparam int S  = 2;
  localparam int E  = 4;
  localparam int H  = 2;
  localparam int W  = 10;
  localparam int LW = 30;
  localparam int PW = 20;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       req_i  = 1'b0;
  logic       rs_i   = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       on_i   = 1'b0;
  logic       ready_o, LCD_RS, LCD_RW, LCD_EN, LCD_ON;
  logic [7:0] LCD_DATA;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .WAIT_CYC(W), .LONG_WAIT_CYC(LW), .PWRUP_CYC(PW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .rs_i(rs_i), .data_i(data_i),
    .on_i(on_i), .ready_o(ready_o), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted write is a transaction of known length; outputs follow from
  // the cycle offset within it.
  logic       m_active, m_ready, m_rs, m_on;
  logic [7:0] m_data;
  int         m_k, m_len, m_pwr;
  int         m_accepts = 0;
  logic [8:0] exp_q[$];
  logic [7:0] init_q[$];

  function automatic int settle_of(input logic r, input logic [7:0] d);
    return (!r && d >= 8'h01 && d <= 8'h03) ? LW : W;
  endfunction

  function automatic void m_start(input logic r, input logic [7:0] d);
    m_active = 1'b1;
    m_k      = 0;
    m_rs     = r;
    m_data   = d;
    m_ready  = 1'b0;
    m_len    = S + E + H + settle_of(r, d) + 1;
    exp_q.push_back({r, d});
    m_accepts++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
      m_rs     = 1'b0;
      m_data   = 8'h00;
      m_on     = 1'b0;
      m_k      = 0;
      m_len    = 0;
      exp_q.delete();
      init_q.delete();
`ifdef LCD_INIT_EN
      m_pwr  = PW;
      init_q = '{8'h38, 8'h0C, 8'h01, 8'h06};
`else
      m_pwr  = 0;
`endif
    end else begin
      m_on = on_i;
      if (m_active) begin
        m_k++;
        if (m_k == m_len - 1 && init_q.size() > 0) m_start(1'b0, init_q.pop_front());
        else if (m_k == m_len) begin
          m_active = 1'b0;
          m_ready  = 1'b1;
        end
      end else if (m_pwr > 0) begin
        m_pwr--;
        if (m_pwr == 0) m_start(1'b0, init_q.pop_front());
      end else if (m_ready && req_i) begin
        m_start(rs_i, data_i);
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Compare process plus scoreboard of EN pulses.
  int         rises = 0;
  logic       prev_en = 1'b0;
  logic [8:0] exp_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      check("ready", ready_o, m_ready);
      check("en", LCD_EN, (m_active && m_k >= S && m_k < S + E));
      check("rw", LCD_RW, 1'b0);
      check("on", LCD_ON, m_on);
      if (m_active && m_k < S + E + H) begin
        check("rs", LCD_RS, m_rs);
        check("data", LCD_DATA, m_data);
      end
      if (LCD_EN && !prev_en) begin
        rises++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got pulse rs=%0h data=%0h expected none at %0t", LCD_RS, LCD_DATA, $time);
        end else begin
          exp_word = exp_q.pop_front();
          if ({LCD_RS, LCD_DATA} !== exp_word) begin
            errors++;
            $display("FAIL pulse_word: got %0h expected %0h at %0t", {LCD_RS, LCD_DATA}, exp_word, $time);
          end
        end
      end
      prev_en = LCD_EN;
    end
  end

  task automatic wait_ready(input string name, input int limit);
    int w;
    w = 0;
    while (!ready_o && w < limit) begin
      @(negedge clk);
      w++;
    end
    check({name, "_ready_wait"}, ready_o, 1'b1);
  endtask

  task automatic write_timed(input logic r, input logic [7:0] d, input int exp_lat, input string name);
    int k, en_cnt;
    wait_ready(name, 200);
    req_i = 1'b1; rs_i = r; data_i = d;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    k = 0; en_cnt = 0;
    while (!ready_o && k < 200) begin
      if (LCD_EN) en_cnt++;
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, exp_lat);
    check({name, "_en_width"}, en_cnt, 4);
  endtask

  task automatic busy_drop();
    int r0;
    wait_ready("busy", 200);
    r0 = rises;
    req_i = 1'b1; rs_i = 1'b1; data_i = 8'h55;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_in_pulse", LCD_EN, 1'b1);
    req_i = 1'b1; data_i = 8'hAA;
    @(negedge clk);
    req_i = 1'b0;
    repeat (7) @(negedge clk);
    req_i = 1'b1; data_i = 8'hBB;
    @(negedge clk);
    req_i = 1'b0;
    wait_ready("busy_end", 200);
    check("busy_drop_pulses", rises - r0, 1);
  endtask

  task automatic back_to_back();
    int   rise_k[$];
    logic [7:0] rise_d[$];
    logic p;
    wait_ready("b2b", 200);
    req_i = 1'b1; rs_i = 1'b1; data_i = 8'h48;
    @(posedge clk);
    @(negedge clk);
    data_i = 8'h49;
    p = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (LCD_EN && !p) begin
        rise_k.push_back(k);
        rise_d.push_back(LCD_DATA);
      end
      p = LCD_EN;
      if (rise_k.size() == 2) break;
      @(negedge clk);
    end
    req_i = 1'b0;
    check("b2b_rises", rise_k.size(), 2);
    if (rise_k.size() == 2) begin
      check("b2b_first_k", rise_k[0], 2);
      check("b2b_second_k", rise_k[1], 22);
      check("b2b_first_data", rise_d[0], 8'h48);
      check("b2b_second_data", rise_d[1], 8'h49);
    end
  endtask

  task automatic reset_mid();
    int r0;
    wait_ready("rst", 200);
    req_i = 1'b1; rs_i = 1'b1; data_i = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_en", LCD_EN, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_en_drop", LCD_EN, 1'b0);
    check("rst_ready", ready_o, 1'b0);
    check("rst_rs", LCD_RS, 1'b0);
    check("rst_data", LCD_DATA, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    r0 = rises;
`ifdef LCD_INIT_EN
    @(negedge clk);
    wait_ready("rst_init", 400);
    check("rst_reinit_pulses", rises - r0, 4);
`else
    repeat (40) @(negedge clk);
    check("rst_ready_after", ready_o, 1'b1);
    check("rst_no_retry", rises - r0, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", ready_o, 1'b0);
    check("reset_en", LCD_EN, 1'b0);
    check("reset_rs", LCD_RS, 1'b0);
    check("reset_data", LCD_DATA, 8'h00);
    check("reset_rw", LCD_RW, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
`ifdef LCD_INIT_EN
    check("init_ready_low", ready_o, 1'b0);
    wait_ready("init", 400);
    check("init_pulses", rises, 4);
    check("init_queue_empty", exp_q.size(), 0);
`else
    check("ready_after_reset", ready_o, 1'b1);
`endif

    write_timed(1'b1, 8'h41, 19, "data_41");
    write_timed(1'b0, 8'h01, 39, "clear");
    write_timed(1'b0, 8'h03, 39, "home_03");
    write_timed(1'b0, 8'h04, 19, "cmd_04");
    write_timed(1'b0, 8'h00, 19, "cmd_00");
    write_timed(1'b1, 8'h01, 19, "data_01");
    busy_drop();
    back_to_back();
    reset_mid();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_i  = ($urandom_range(0, 2) == 0);
      rs_i   = 1'($urandom_range(0, 1));
      data_i = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) on_i = ~on_i;
    end
    @(negedge clk);
    req_i = 1'b0;
    wait_ready("random_end", 200);
    repeat (2) @(negedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_pulse_count", rises, m_accepts);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
